// File: rtl/aes_pkg.sv
// Shared AES datapath constants and block/word types.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;

endpackage : aes_pkg

// File: rtl/shift_register_128to32_if.sv
// Bus between the 128-bit AES core side and the 32-bit word consumer.
// master: drives the block and the load/shift strobes, observes the word stream.
// slave:  the shift register itself.
interface shift_register_128to32_if
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_BLOCK_W,
    parameter int WORD_W = AES_WORD_W
) ();

    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              shift_out;
    logic [WORD_W-1:0] data_out;
    logic              valid;
    logic              last;

    modport master (
        output data_in,
        output load,
        output shift_out,
        input  data_out,
        input  valid,
        input  last
    );

    modport slave (
        input  data_in,
        input  load,
        input  shift_out,
        output data_out,
        output valid,
        output last
    );

endinterface : shift_register_128to32_if

// File: rtl/shift_register_128to32.sv
// Parallel-in, serial-word-out register: captures a block and presents it
// most-significant word first, one word per shift_out strobe.
module shift_register_128to32
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_BLOCK_W,
    parameter int WORD_W = AES_WORD_W
) (
    input  logic                     clk,
    input  logic                     reset,
    shift_register_128to32_if.slave  bus
);

    // DATA_W is expected to be a whole number of words.
    localparam int NUM_WORDS = DATA_W / WORD_W;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);

    logic [DATA_W-1:0] sreg_q;
    logic [DATA_W-1:0] sreg_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    // Next-state: load has priority over shift; a shift on an empty register is ignored.
    always_comb begin
        sreg_d  = sreg_q;
        count_d = count_q;
        if (bus.load) begin
            sreg_d  = bus.data_in;
            count_d = CNT_W'(NUM_WORDS);
        end else if (bus.shift_out && (count_q != '0)) begin
            // Zero fill keeps data_out at 0 once the last word has gone.
            sreg_d  = sreg_q << WORD_W;
            count_d = count_q - CNT_W'(1);
        end
    end

    // State register; reset discards any words still pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q  <= '0;
            count_q <= '0;
        end else begin
            sreg_q  <= sreg_d;
            count_q <= count_d;
        end
    end

    // Outputs decode registered state only, so there is no input-to-output path.
    assign bus.data_out = sreg_q[DATA_W-1 -: WORD_W];
    assign bus.valid    = (count_q != '0);
    assign bus.last     = (count_q == CNT_W'(1));

endmodule : shift_register_128to32

// File: tb/tb_shift_register_128to32.sv
// Scoreboard bench: a word-queue reference model predicts the output after
// every clock edge; a monitor on the falling edge pops and compares.
module tb_shift_register_128to32;
    import aes_pkg::*;

    typedef struct {
        logic [31:0] d;
        logic        v;
        logic        l;
    } exp_t;

    logic clk;
    logic reset;

    shift_register_128to32_if bus ();

    shift_register_128to32 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the words still to be delivered, head first.
    logic [31:0] model_q[$];
    exp_t        sb[$];

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    task automatic model_edge(input logic r, input logic ld, input logic sh,
                              input logic [127:0] din);
        logic [127:0] tmp;
        if (r) begin
            model_q.delete();
        end else if (ld) begin
            model_q.delete();
            for (int i = 0; i < 4; i++) begin
                tmp = din >> (32 * (3 - i));
                model_q.push_back(tmp[31:0]);
            end
        end else if (sh && model_q.size() > 0) begin
            void'(model_q.pop_front());
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.d = (model_q.size() > 0) ? model_q[0] : 32'h0;
        e.v = (model_q.size() > 0);
        e.l = (model_q.size() == 1);
        sb.push_back(e);
    endtask

    // One clock cycle of stimulus, applied just after the falling edge.
    task automatic step(input logic r, input logic ld, input logic sh,
                        input logic [127:0] din);
        @(negedge clk);
        #1;
        reset         = r;
        bus.load      = ld;
        bus.shift_out = sh;
        bus.data_in   = din;
        model_edge(r, ld, sh, din);
        push_expected();
        @(posedge clk);
    endtask

    // Monitor: each falling edge shows the result of the preceding rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                txn++;
                $display("txn %0d: data_out=%h valid=%b last=%b (expect %h %b %b)",
                         txn, bus.data_out, bus.valid, bus.last, e.d, e.v, e.l);
                if (bus.data_out !== e.d || bus.valid !== e.v || bus.last !== e.l) begin
                    errors++;
                    $display("FAIL txn %0d: got data_out=%h valid=%b last=%b, want data_out=%h valid=%b last=%b",
                             txn, bus.data_out, bus.valid, bus.last, e.d, e.v, e.l);
                end
            end
        end
    end

    localparam logic [127:0] BLK_A = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] BLK_F = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;

    initial begin
        logic [127:0] rnd;
        logic         r;
        logic         ld;
        logic         sh;
        int           drain;

        reset         = 1'b1;
        bus.load      = 1'b0;
        bus.shift_out = 1'b0;
        bus.data_in   = '0;

        // Reset held two cycles with load asserted: reset must win.
        rnd = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, 1'b1, 1'b0, rnd);
        step(1'b1, 1'b1, 1'b1, rnd);
        step(1'b0, 1'b0, 1'b0, '0);

        // Load then stream all four words, then shift while empty.
        step(1'b0, 1'b1, 1'b0, BLK_A);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, '0);

        // Load priority mid-stream.
        step(1'b0, 1'b1, 1'b0, BLK_A);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b1, 1'b1, BLK_F);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, '0);

        // Hold with nothing asserted.
        step(1'b0, 1'b1, 1'b0, BLK_A);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, '0);

        // Reset mid-stream, then a shift that must do nothing.
        step(1'b0, 1'b1, 1'b0, BLK_A);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            r   = ($urandom_range(0, 29) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            sh  = ($urandom_range(0, 2) != 0);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            step(r, ld, sh, rnd);
        end
        step(1'b0, 1'b0, 1'b0, '0);

        // Let the monitor drain the scoreboard, with a bound.
        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(negedge clk);
            #1;
            drain++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected transactions never compared, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_shift_register_128to32

// File: doc/shift_register_128to32.md
Name: shift_register_128to32

Overview:
- Parallel-in, serial-word-out register for the AES128 datapath.
- Captures a 128-bit block (state, key or ciphertext) and presents it as four 32-bit words on a narrow bus.
- Words leave most-significant first: bits 127:96, then 95:64, 63:32, 31:0.
- Sits between the 128-bit AES core and a 32-bit output interface.

Parameters:
- DATA_W, 128, width of the parallel input block.
- WORD_W, 32, width of each output word; DATA_W must be an integer multiple of WORD_W.
- NUM_WORDS, DATA_W/WORD_W (4), derived local parameter, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  parallel block, sampled when load=1.
- load  input  1  capture data_in on this rising edge.
- shift_out  input  1  advance to the next word on this rising edge.
- data_out  output  WORD_W  current word, equal to the top WORD_W bits of the internal register.
- valid  output  1  high while data_out holds an unconsumed word.
- last  output  1  high when data_out holds the final word of the block (valid && count==1).

Behaviour:
- Interface: one clock domain (clk); reset is synchronous and active-high.
- State:
  - sreg[DATA_W-1:0] holds the block.
  - count[$clog2(NUM_WORDS+1)-1:0] holds the words remaining.
- Reset, sampled at the clk edge: sreg=0, count=0, so data_out=0, valid=0, last=0.
  - Reset overrides load and shift_out.
  - Reset mid-stream discards the remaining words.
- Load (reset=0, load=1): sreg<=data_in, count<=NUM_WORDS.
  - Next cycle: data_out=data_in[127:96], valid=1.
  - Latency is one clock.
- Shift (reset=0, load=0, shift_out=1, count>0): sreg<=sreg<<WORD_W with zero fill; count<=count-1.
  - The next word appears on data_out the following cycle.
- Shift when count==0: ignored; sreg and count hold, data_out remains 0.
- load and shift_out both high: load wins and the current word is discarded. A new load mid-stream restarts at word 0 of the new block.
- Neither input asserted: all state holds.
- Continuous shift_out: one word per cycle. After the 4th word is consumed, data_out=0 and valid=0.
- data_out, valid and last are combinational decodes of registered state only; there is no combinational path from any input.
- No wrap-around: shifted-out words are not recirculated.

Decomposition:
- Shared package aes_pkg:
  - localparams AES_BLOCK_W=128 and AES_WORD_W=32.
  - typedefs aes_block_t (logic[127:0]) and aes_word_t (logic[31:0]).
- Single flat module; no sub-module is warranted. The counter and shifter are inline.

Test Plan:
- Reset: hold reset=1 for 2 cycles with load=1 and arbitrary data_in -> data_out=0, valid=0, last=0 after the release edge.
- Load and stream: load data_in=128'h0123456789ABCDEF0123456789ABCDEF for 1 cycle, then shift_out=1 continuously.
  - Words: 32'h01234567, 32'h89ABCDEF, 32'h01234567, 32'h89ABCDEF.
  - last=1 on the 4th word only.
  - Then data_out=0, valid=0.
- Shift when empty: after the stream, hold shift_out=1 for 3 more cycles -> data_out stays 0 and valid stays 0.
- Load priority: mid-stream at word 2, assert load=1 and shift_out=1 with data_in=128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC.
  - Next cycle: data_out=32'hFFFFFFFF, valid=1, count reset to 4.
- Hold: after load with shift_out=0 for 5 cycles -> data_out steadily 32'h01234567, valid=1.
- Reset mid-stream: after 2 shifts, assert reset with shift_out=1 -> data_out=0, valid=0 next cycle. A subsequent shift has no effect.
